// File: rtl/bi_serializer_if.sv
// Load handshake and serial output bundle for bi_serializer.
// master = word source / line consumer, slave = the serializer itself.
interface bi_serializer_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] Din;
  logic             dir;
  logic             load_valid;
  logic             load_ready;
  logic             shift_en;
  logic             Sout;
  logic             Sout_valid;
  logic             busy;
  logic             done;

  modport master (
    output Din, dir, load_valid, shift_en,
    input  load_ready, Sout, Sout_valid, busy, done
  );

  modport slave (
    input  Din, dir, load_valid, shift_en,
    output load_ready, Sout, Sout_valid, busy, done
  );
endinterface

// File: rtl/bi_serializer.sv
// Parallel-in serial-out shifter with per-word LSB/MSB-first order.
// Optional even-parity trailer bit when BI_SERIALIZER_PARITY_EN is defined.
module bi_serializer #(
  parameter int WIDTH = 4
) (
  input logic            clk,
  input logic            reset,
  bi_serializer_if.slave bus
);

`ifdef BI_SERIALIZER_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CW = $clog2(FRAME + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
  logic             dir_q, dir_d;
  logic             sout_q, sout_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             last, ready, accept, data_next, bit_next;
`ifdef BI_SERIALIZER_PARITY_EN
  logic             par_q, par_d;
`endif

  // The bit currently on Sout sits at shreg[0] (LSB-first) or shreg[WIDTH-1]
  // (MSB-first); its neighbour toward the latched order is the next data bit.
  always_comb begin
    last      = (state_q == SHIFT) && (cnt_q == LAST_IDX);
    ready     = (state_q == IDLE) || (last && bus.shift_en);
    accept    = bus.load_valid && ready;
    cnt_inc   = cnt_q + CW'(1);
    data_next = dir_q ? shreg_q[1] : shreg_q[WIDTH-2];
`ifdef BI_SERIALIZER_PARITY_EN
    bit_next  = (cnt_inc == CW'(WIDTH)) ? par_q : data_next;
`else
    bit_next  = data_next;
`endif
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    sout_d  = sout_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef BI_SERIALIZER_PARITY_EN
    par_d   = par_q;
`endif
    if (accept) begin
      state_d = SHIFT;
      shreg_d = bus.Din;
      cnt_d   = '0;
      dir_d   = bus.dir;
      sout_d  = bus.dir ? bus.Din[0] : bus.Din[WIDTH-1];
      valid_d = 1'b1;
      busy_d  = 1'b1;
`ifdef BI_SERIALIZER_PARITY_EN
      par_d   = ^bus.Din;
`endif
    end else begin
      case (state_q)
        SHIFT: begin
          if (bus.shift_en) begin
            if (last) begin
              state_d = IDLE;
              cnt_d   = '0;
              sout_d  = 1'b0;
              valid_d = 1'b0;
              busy_d  = 1'b0;
            end else begin
              cnt_d   = cnt_inc;
              shreg_d = dir_q ? (shreg_q >> 1) : (shreg_q << 1);
              sout_d  = bit_next;
              done_d  = (cnt_inc == LAST_IDX);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      sout_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef BI_SERIALIZER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      sout_q  <= sout_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef BI_SERIALIZER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign bus.load_ready = ready;
  assign bus.Sout       = sout_q;
  assign bus.Sout_valid = valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_bi_serializer.sv
// Scoreboard bench for bi_serializer: driver pushes expected frame bits on
// accept, a negedge monitor pops and checks each newly presented bit.
module tb_bi_serializer;
  localparam int WIDTH = 4;
`ifdef BI_SERIALIZER_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif

  typedef struct packed {
    logic b;
    logic last;
  } item_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bi_serializer_if #(.WIDTH(WIDTH)) bus ();
  bi_serializer #(.WIDTH(WIDTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  item_t       q[$];
  int          total = 0;
  int          bad = 0;
  int          mode = 0;
  bit          mon_en = 1'b0;
  int unsigned tick = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // shift_en pattern: 0 = held high, 1 = every 3rd cycle, 2 = random
  initial begin
    bus.shift_en = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tick++;
      case (mode)
        0:       bus.shift_en = 1'b1;
        1:       bus.shift_en = (tick % 3 == 0);
        default: bus.shift_en = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Reference frame: data bits in the chosen order, then optional parity.
  task automatic push_frame(input logic [WIDTH-1:0] w, input logic d);
    item_t it;
    for (int i = 0; i < FRAME; i++) begin
      if (i < WIDTH) it.b = d ? w[i] : w[WIDTH-1-i];
      else           it.b = ^w;
      it.last = (i == FRAME - 1);
      q.push_back(it);
    end
  endtask

  task automatic send(input logic [WIDTH-1:0] w, input logic d);
    bit acc;
    bit ok = 1'b0;
    bus.Din        = w;
    bus.dir        = d;
    bus.load_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      acc = bus.load_valid && bus.load_ready;
      @(posedge clk);
      if (acc) begin
        push_frame(w, d);
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check("accept_timeout", 0, 1);
      bus.load_valid = 1'b0;
    end
    #1;
  endtask

  task automatic idle(input int n);
    bus.load_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      bus.dir = ~bus.dir;
      bus.Din = WIDTH'($urandom);
    end
  endtask

  bit    holding = 1'b0;
  bit    hold_last = 1'b0;
  bit    hb = 1'b0;
  bit    exp_new = 1'b0;
  item_t cur;

  initial begin
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        holding = 1'b0;
        exp_new = 1'b0;
      end else begin
        if (exp_new && q.size() > 0) begin
          cur       = q.pop_front();
          holding   = 1'b1;
          hb        = cur.b;
          hold_last = cur.last;
          check("done", bus.done, cur.last);
        end else begin
          if (exp_new) holding = 1'b0;
          check("done", bus.done, 0);
        end
        check("valid", bus.Sout_valid, holding);
        check("busy", bus.busy, holding);
        check("sout", bus.Sout, holding ? hb : 1'b0);
        check("ready", bus.load_ready, !holding || (hold_last && bus.shift_en));
        exp_new = (holding && bus.shift_en) || (bus.load_valid && bus.load_ready);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset          = 1'b0;
    bus.load_valid = 1'b0;
    bus.Din        = '0;
    bus.dir        = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("rst_sout", bus.Sout, 0);
    check("rst_valid", bus.Sout_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_ready", bus.load_ready, 1);
    mon_en = 1'b1;

    mode = 0;
    send(4'b1101, 1'b1);
    idle(FRAME + 2);
    send(4'b1101, 1'b0);
    idle(FRAME + 2);
    mode = 1;
    send(4'b0110, 1'b1);
    idle(3 * FRAME + 6);
    mode = 0;
    send(4'b1010, 1'b1);
    send(4'b0011, 1'b1);
    idle(FRAME + 2);

    // Abort a word after its second bit with an asynchronous reset.
    send(4'b1111, 1'b1);
    bus.load_valid = 1'b0;
    @(posedge clk);
    #3;
    mon_en = 1'b0;
    reset  = 1'b0;
    #1;
    check("abort_sout", bus.Sout, 0);
    check("abort_valid", bus.Sout_valid, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    mon_en = 1'b1;
    send(4'b0001, 1'b0);
    idle(FRAME + 2);

    mode = 2;
    for (int k = 0; k < 30; k++) begin
      send(WIDTH'($urandom), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(0, 3)));
    end
    mode = 0;
    for (int k = 0; k < 20; k++) send(WIDTH'($urandom), 1'($urandom_range(0, 1)));
    idle(4 * FRAME);
    check("drain", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
